dijkstra_node_ram_mp: RTL and testbench

Parametrised multi-read-port node memory for the pathfinding engine. It holds per-node records (distance/predecessor/visited fields packed into one word) for the Dijkstra core. It adds the following:
- a hardware init sweep that fills every entry with INIT_VALUE after reset or on request;
- N independent registered read ports with valid flags;
- optional read-during-write forwarding;
- out-of-range address detection.
It sits between the Dijkstra control FSM and on-chip M10K storage.

---
 rtl/dijkstra_node_ram_mp.sv | 161 ++++++++++++++++
 tb/tb_dijkstra_node_ram_mp.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dijkstra_node_ram_mp.sv
// Multi-read-port node record memory for the Dijkstra engine: one RAM replica per read port,
// hardware init sweep, registered reads with optional write forwarding, and range checking.
module dijkstra_node_ram_mp #(
  parameter int unsigned           DATA_WIDTH     = 14,
  parameter int unsigned           ADDR_WIDTH     = 9,
  parameter int unsigned           DEPTH          = 15,
  parameter int unsigned           NUM_READ_PORTS = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '1,
  parameter bit                    BYPASS         = 1'b1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               clear_start,
  input  logic                               wr_en,
  input  logic [ADDR_WIDTH-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic [NUM_READ_PORTS-1:0]          rd_en,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ_PORTS-1:0]          rd_valid,
  output logic                               ready,
  output logic                               init_done,
  output logic                               addr_error
);

  localparam int unsigned      IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        sweep_cnt_q, sweep_cnt_d;
  logic                    ready_q, ready_d;
  logic                    init_done_q, init_done_d;
  logic                    addr_error_q, addr_error_d;

  logic                      wr_oor_c;
  logic [NUM_READ_PORTS-1:0] rd_oor_c;
  logic                      wr_fire_c;
  logic                      mem_we_c;
  logic [IDX_W-1:0]          mem_waddr_c;
  logic [DATA_WIDTH-1:0]     mem_wdata_c;

  // Range checks are done at full address width so aliasing addresses are never accepted
  always_comb begin
    wr_oor_c = 32'(wr_addr) >= DEPTH;
    rd_oor_c = '0;
    for (int p = 0; p < int'(NUM_READ_PORTS); p++) begin
      rd_oor_c[p] = 32'(rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]) >= DEPTH;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      sweep_cnt_q  <= '0;
      ready_q      <= 1'b0;
      init_done_q  <= 1'b0;
      addr_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_cnt_q  <= sweep_cnt_d;
      ready_q      <= ready_d;
      init_done_q  <= init_done_d;
      addr_error_q <= addr_error_d;
    end
  end

  // clear_start overrides everything, including a same-cycle write
  always_comb begin
    state_d      = state_q;
    sweep_cnt_d  = sweep_cnt_q;
    ready_d      = ready_q;
    init_done_d  = 1'b0;
    addr_error_d = addr_error_q;
    wr_fire_c    = 1'b0;
    mem_we_c     = 1'b0;
    mem_waddr_c  = sweep_cnt_q;
    mem_wdata_c  = INIT_VALUE;
    if (clear_start) begin
      state_d      = ST_INIT;
      sweep_cnt_d  = '0;
      ready_d      = 1'b0;
      addr_error_d = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          mem_we_c = 1'b1;
          if (sweep_cnt_q == LAST_IDX) begin
            state_d     = ST_READY;
            ready_d     = 1'b1;
            init_done_d = 1'b1;
          end else begin
            sweep_cnt_d = sweep_cnt_q + IDX_W'(1);
          end
        end
        ST_READY: begin
          wr_fire_c = wr_en && !wr_oor_c;
          if (wr_fire_c) begin
            mem_we_c    = 1'b1;
            mem_waddr_c = wr_addr[IDX_W-1:0];
            mem_wdata_c = wr_data;
          end
          if ((wr_en && wr_oor_c) || (|(rd_en & rd_oor_c))) begin
            addr_error_d = 1'b1;
          end
        end
      endcase
    end
  end

  for (genvar p = 0; p < int'(NUM_READ_PORTS); p++) begin : g_port
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [ADDR_WIDTH-1:0] raddr_c;
    logic                  hit_c;

    assign raddr_c = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit_c   = BYPASS && wr_fire_c && (raddr_c == wr_addr);

    // Replica RAM: no reset, every write is mirrored into each port's copy
    always_ff @(posedge clk) begin
      if (mem_we_c) begin
        mem_q[mem_waddr_c] <= mem_wdata_c;
      end
    end

    always_comb begin
      rd_valid_d = ready_q && rd_en[p];
      rd_data_d  = rd_data_q;
      if (rd_valid_d) begin
        if (rd_oor_c[p]) begin
          rd_data_d = INIT_VALUE;
        end else if (hit_c) begin
          rd_data_d = wr_data;
        end else begin
          rd_data_d = mem_q[raddr_c[IDX_W-1:0]];
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_valid_q <= 1'b0;
        rd_data_q  <= '0;
      end else begin
        rd_valid_q <= rd_valid_d;
        rd_data_q  <= rd_data_d;
      end
    end

    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_data_q;
    assign rd_valid[p]                         = rd_valid_q;
  end

  assign ready      = ready_q;
  assign init_done  = init_done_q;
  assign addr_error = addr_error_q;

endmodule

// File: tb/tb_dijkstra_node_ram_mp.sv
// Scoreboard bench for dijkstra_node_ram_mp: a forwarding and a non-forwarding instance share stimulus.
module tb_dijkstra_node_ram_mp;

  localparam int unsigned DW    = 14;
  localparam int unsigned AW    = 9;
  localparam int unsigned NP    = 2;
  localparam int unsigned DEPTH = 15;
  localparam logic [DW-1:0] INF = 14'h3FFF;

  logic clk = 1'b0;
  logic reset_n, clear_start, wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [NP-1:0]    rd_en;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*DW-1:0] rd_data, rd_data_nb;
  logic [NP-1:0]    rd_valid, rd_valid_nb;
  logic ready, ready_nb, init_done, init_done_nb, addr_error, addr_error_nb;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [DW-1:0] nb;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [DW-1:0] m_mem [DEPTH];
  logic          m_ready, m_done, m_err;
  logic [3:0]    m_cnt;
  logic [NP-1:0] m_vld;
  logic [DW-1:0] m_last [NP];
  logic [DW-1:0] m_last_nb [NP];

  int n_checks;
  int n_errors;

  always #5 clk = ~clk;

  dijkstra_node_ram_mp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_READ_PORTS(NP),
    .INIT_VALUE(INF), .BYPASS(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear_start(clear_start), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .ready(ready), .init_done(init_done),
    .addr_error(addr_error)
  );

  dijkstra_node_ram_mp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_READ_PORTS(NP),
    .INIT_VALUE(INF), .BYPASS(1'b0)
  ) dut_nb (
    .clk(clk), .reset_n(reset_n), .clear_start(clear_start), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_nb), .rd_valid(rd_valid_nb), .ready(ready_nb), .init_done(init_done_nb),
    .addr_error(addr_error_nb)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    clear_start = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    rd_en       = '0;
    rd_addr     = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_en[p]            = 1'b1;
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
  endtask

  task automatic flush_model();
    m_ready = 1'b0;
    m_done  = 1'b0;
    m_err   = 1'b0;
    m_cnt   = '0;
    m_vld   = '0;
    for (int p = 0; p < int'(NP); p++) begin
      m_last[p]    = '0;
      m_last_nb[p] = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic compare();
    exp_t e;
    check_val("ready", 32'(ready), 32'(m_ready));
    check_val("ready_nb", 32'(ready_nb), 32'(m_ready));
    check_val("init_done", 32'(init_done), 32'(m_done));
    check_val("init_done_nb", 32'(init_done_nb), 32'(m_done));
    check_val("addr_error", 32'(addr_error), 32'(m_err));
    check_val("addr_error_nb", 32'(addr_error_nb), 32'(m_err));
    check_val("rd_valid", 32'(rd_valid), 32'(m_vld));
    check_val("rd_valid_nb", 32'(rd_valid_nb), 32'(m_vld));
    for (int p = 0; p < int'(NP); p++) begin
      if (m_vld[p]) begin
        if (p == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        m_last[p]    = e.d;
        m_last_nb[p] = e.nb;
      end
      check_val($sformatf("rd_data%0d", p), 32'(rd_data[p*DW +: DW]), 32'(m_last[p]));
      check_val($sformatf("rd_data%0d_nb", p), 32'(rd_data_nb[p*DW +: DW]), 32'(m_last_nb[p]));
    end
  endtask

  // One clock: predict from the current inputs, push reads, then compare after the edge
  task automatic cyc();
    exp_t          e;
    logic          wfire, err_n, rdy_n, done_n;
    logic [3:0]    cnt_n;
    logic [NP-1:0] vld_n;
    logic [AW-1:0] a;
    wfire = m_ready && wr_en && !clear_start && (wr_addr < AW'(DEPTH));
    vld_n = '0;
    for (int p = 0; p < int'(NP); p++) begin
      if (m_ready && rd_en[p]) begin
        vld_n[p] = 1'b1;
        a = rd_addr[p*AW +: AW];
        if (a >= AW'(DEPTH)) begin
          e.d  = INF;
          e.nb = INF;
        end else begin
          e.nb = m_mem[a[3:0]];
          e.d  = (wfire && wr_addr == a) ? wr_data : m_mem[a[3:0]];
        end
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
    err_n  = m_err;
    rdy_n  = m_ready;
    done_n = 1'b0;
    cnt_n  = m_cnt;
    if (clear_start) begin
      err_n = 1'b0;
      rdy_n = 1'b0;
      cnt_n = '0;
    end else if (!m_ready) begin
      m_mem[m_cnt] = INF;
      if (m_cnt == 4'(DEPTH - 1)) begin
        rdy_n  = 1'b1;
        done_n = 1'b1;
      end else begin
        cnt_n = m_cnt + 4'd1;
      end
    end else begin
      if (wr_en && wr_addr >= AW'(DEPTH)) err_n = 1'b1;
      for (int p = 0; p < int'(NP); p++) begin
        if (rd_en[p] && rd_addr[p*AW +: AW] >= AW'(DEPTH)) err_n = 1'b1;
      end
      if (wfire) m_mem[wr_addr[3:0]] = wr_data;
    end
    @(posedge clk);
    @(negedge clk);
    m_ready = rdy_n;
    m_done  = done_n;
    m_err   = err_n;
    m_cnt   = cnt_n;
    m_vld   = vld_n;
    compare();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int done_cnt;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 14'h0BAD;
    set_idle();
    reset_n = 1'b0;
    flush_model();
    repeat (2) @(negedge clk);
    compare();

    // Sweep after reset release
    reset_n  = 1'b1;
    n        = 0;
    done_cnt = 0;
    while (!ready && n < 40) begin
      cyc();
      n++;
      done_cnt += int'(init_done);
    end
    check_val("sweep_cycles", 32'(n), 32'd15);
    cyc();
    done_cnt += int'(init_done);
    check_val("init_done_pulses", 32'(done_cnt), 32'd1);
    for (int i = 0; i < int'(DEPTH); i++) begin
      set_idle();
      set_rd(0, i);
      set_rd(1, int'(DEPTH) - 1 - i);
      cyc();
    end

    // Write then dual-port read
    set_idle();
    set_wr(3, 14'h0123);
    cyc();
    set_idle();
    set_rd(0, 3);
    set_rd(1, 5);
    cyc();
    check_val("t2_rd_data0", 32'(rd_data[DW-1:0]), 32'h0123);
    check_val("t2_rd_data1", 32'(rd_data[2*DW-1:DW]), 32'h3FFF);
    check_val("t2_rd_valid", 32'(rd_valid), 32'h3);

    // Read-during-write collision on both ports
    set_idle();
    set_wr(7, 14'h0456);
    set_rd(0, 7);
    set_rd(1, 7);
    cyc();
    check_val("t3_bypass_d0", 32'(rd_data[DW-1:0]), 32'h0456);
    check_val("t3_bypass_d1", 32'(rd_data[2*DW-1:DW]), 32'h0456);
    check_val("t3_nobypass_d0", 32'(rd_data_nb[DW-1:0]), 32'h3FFF);
    set_idle();
    set_rd(0, 7);
    cyc();
    check_val("t3_after_d0_nb", 32'(rd_data_nb[DW-1:0]), 32'h0456);

    // Out-of-range access
    set_idle();
    set_rd(0, 20);
    set_wr(20, 14'h1555);
    cyc();
    check_val("t4_oor_data", 32'(rd_data[DW-1:0]), 32'h3FFF);
    check_val("t4_oor_valid", 32'(rd_valid[0]), 32'd1);
    check_val("t4_addr_error", 32'(addr_error), 32'd1);
    for (int i = 0; i < int'(DEPTH); i++) begin
      set_idle();
      set_rd(0, i);
      set_rd(1, i);
      cyc();
    end
    check_val("t4_error_sticky", 32'(addr_error), 32'd1);

    // clear_start in READY drops the concurrent write, then restart mid-sweep
    set_idle();
    clear_start = 1'b1;
    set_wr(7, 14'h0111);
    set_rd(0, 7);
    cyc();
    check_val("t5_dropped_fwd", 32'(rd_data[DW-1:0]), 32'h0456);
    check_val("t5_error_clear", 32'(addr_error), 32'd0);
    n = 0;
    while (m_cnt != 4'd6 && n < 20) begin
      set_idle();
      set_wr(1, 14'h0222);
      set_rd(0, 1);
      set_rd(1, 2);
      cyc();
      n++;
    end
    set_idle();
    clear_start = 1'b1;
    set_wr(2, 14'h0333);
    cyc();
    set_idle();
    n = 0;
    while (!ready && n < 40) begin
      cyc();
      n++;
    end
    check_val("t5_restart_cycles", 32'(n), 32'd15);

    // Random traffic including collisions and out-of-range addresses
    for (int i = 0; i < 200; i++) begin
      set_idle();
      if ($urandom_range(0, 2) != 0) set_wr(int'($urandom_range(0, 19)), DW'($urandom));
      for (int p = 0; p < int'(NP); p++) begin
        if ($urandom_range(0, 3) != 0) set_rd(p, int'($urandom_range(0, 19)));
      end
      cyc();
    end

    // Async reset with reads in flight
    set_idle();
    set_wr(3, 14'h0777);
    cyc();
    set_idle();
    set_rd(0, 3);
    set_rd(1, 3);
    cyc();
    check_val("t6_pre_valid", 32'(rd_valid), 32'h3);
    #1 reset_n = 1'b0;
    #1;
    check_val("t6_async_valid", 32'(rd_valid), 32'h0);
    check_val("t6_async_ready", 32'(ready), 32'd0);
    flush_model();
    compare();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    set_idle();
    n = 0;
    while (!ready && n < 40) begin
      cyc();
      n++;
    end
    check_val("t6_sweep_cycles", 32'(n), 32'd15);
    set_idle();
    set_rd(0, 3);
    set_rd(1, 7);
    cyc();
    check_val("t6_reread3", 32'(rd_data[DW-1:0]), 32'h3FFF);
    for (int i = 0; i < int'(DEPTH); i++) begin
      set_idle();
      set_rd(0, i);
      cyc();
    end
    set_idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
